// File: rtl/i2c_seq_pkg.sv
// Shared types, widths and the default codec-init table for the I2C command sequencer.
// Optional retry support in the top is compiled in with I2C_SEQ_RETRY_EN.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_ACK_LO,
    ST_ACK_HI,
    ST_STOP_LO,
    ST_STOP_HI,
    ST_STOP_REL,
    ST_DONE
  } state_e;

  localparam int BITS_PER_BYTE = 8;
  localparam int BIT_W         = 3;
  localparam int CODEC_N_CMD   = 10;

  // Counter width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Codec power-up sequence: {slave address, register, value}.
  function automatic logic [23:0] codec_init_cmd(input int idx);
    logic [23:0] cmd;
    case (idx)
      0:       cmd = 24'h34_1E_00;
      1:       cmd = 24'h34_0C_10;
      2:       cmd = 24'h34_0E_02;
      3:       cmd = 24'h34_10_00;
      4:       cmd = 24'h34_00_17;
      5:       cmd = 24'h34_02_17;
      6:       cmd = 24'h34_08_12;
      7:       cmd = 24'h34_0A_00;
      8:       cmd = 24'h34_0C_00;
      9:       cmd = 24'h34_12_01;
      default: cmd = 24'h34_1E_00;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Bus-phase timer: counts 0..CLK_DIV-1 while enabled and pulses o_tc on the last count.
module i2c_phase_timer
  import i2c_seq_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CNT_W = clog2_min1(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_tc = i_en && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_tc) cnt_d = '0;
    else if (i_en)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Write-only I2C command sequencer: walks N_CMD fixed-length commands as START/bytes/STOP.
// Define I2C_SEQ_RETRY_EN to retry a NACKed command up to MAX_RETRY times before aborting.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int N_CMD         = 10,
  parameter int BYTES_PER_CMD = 3,
  parameter int CLK_DIV       = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic [BYTES_PER_CMD*8-1:0]        i_cmd_data,
  output logic [clog2_min1(N_CMD)-1:0]      o_cmd_idx,
  output logic                              o_busy,
  output logic                              o_finished,
  output logic                              o_error,
  output logic                              o_sclk,
  inout  wire                               io_sdat,
  output logic                              o_oen
);

  localparam int SHW    = BYTES_PER_CMD * BITS_PER_BYTE;
  localparam int IDX_W  = clog2_min1(N_CMD);
  localparam int BYTE_W = clog2_min1(BYTES_PER_CMD);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CMD - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_CMD - 1);

  state_e              state_q, state_d;
  logic [SHW-1:0]      shift_q, shift_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                nack_q, nack_d;
  logic                err_q, err_d;
`ifdef I2C_SEQ_RETRY_EN
  localparam int RTY_W = clog2_min1(MAX_RETRY + 1);
  logic [RTY_W-1:0]    retry_q, retry_d;
`endif

  logic sclk_q, sclk_d;
  logic sda_q, sda_d;
  logic oen_q, oen_d;
  logic busy_q, busy_d;
  logic fin_q, fin_d;

  logic tc;
  logic tmr_en;

  assign tmr_en = (state_q != ST_IDLE) && (state_q != ST_DONE);

  i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (tmr_en),
    .i_clr   (state_q == ST_IDLE),
    .o_tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    nack_d  = nack_q;
    err_d   = err_q;
`ifdef I2C_SEQ_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d = ST_START;
        err_d   = 1'b0;
        idx_d   = '0;
        nack_d  = 1'b0;
        bit_d   = '0;
        byte_d  = '0;
`ifdef I2C_SEQ_RETRY_EN
        retry_d = '0;
`endif
      end
      ST_START: if (tc) begin
        shift_d = i_cmd_data;
        state_d = ST_BIT_LO;
      end
      ST_BIT_LO: if (tc) state_d = ST_BIT_HI;
      ST_BIT_HI: if (tc) begin
        shift_d = {shift_q[SHW-2:0], 1'b0};
        if (bit_q == BIT_W'(BITS_PER_BYTE - 1)) begin
          bit_d   = '0;
          state_d = ST_ACK_LO;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_BIT_LO;
        end
      end
      ST_ACK_LO: if (tc) state_d = ST_ACK_HI;
      ST_ACK_HI: if (tc) begin
        // Released line reads high through the bus pull-up: anything but 0 is a NACK.
        if (io_sdat != 1'b0) begin
          nack_d  = 1'b1;
          state_d = ST_STOP_LO;
        end else if (byte_q == LAST_BYTE) begin
          state_d = ST_STOP_LO;
        end else begin
          byte_d  = byte_q + 1'b1;
          state_d = ST_BIT_LO;
        end
      end
      ST_STOP_LO: if (tc) state_d = ST_STOP_HI;
      ST_STOP_HI: if (tc) state_d = ST_STOP_REL;
      ST_STOP_REL: if (tc) begin
        bit_d  = '0;
        byte_d = '0;
        nack_d = 1'b0;
        if (!nack_q) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
`ifdef I2C_SEQ_RETRY_EN
            retry_d = '0;
`endif
            state_d = ST_START;
          end
        end else begin
`ifdef I2C_SEQ_RETRY_EN
          if (retry_q != RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_START;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
`else
          err_d   = 1'b1;
          state_d = ST_DONE;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus pins are decoded from the next state so they register in step with state_q.
  always_comb begin
    sclk_d = 1'b1;
    sda_d  = 1'b1;
    oen_d  = 1'b1;
    case (state_d)
      ST_START:   sda_d = 1'b0;
      ST_BIT_LO:  begin sclk_d = 1'b0; sda_d = shift_d[SHW-1]; end
      ST_BIT_HI:  sda_d = shift_d[SHW-1];
      ST_ACK_LO:  begin sclk_d = 1'b0; oen_d = 1'b0; end
      ST_ACK_HI:  oen_d = 1'b0;
      ST_STOP_LO: begin sclk_d = 1'b0; sda_d = 1'b0; end
      ST_STOP_HI: sda_d = 1'b0;
      default:    ;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    fin_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
      sclk_q  <= 1'b1;
      sda_q   <= 1'b1;
      oen_q   <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
      sclk_q  <= sclk_d;
      sda_q   <= sda_d;
      oen_q   <= oen_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) retry_q <= '0;
    else          retry_q <= retry_d;
  end
`endif

  assign io_sdat    = oen_q ? sda_q : 1'bz;
  assign o_sclk     = sclk_q;
  assign o_oen      = oen_q;
  assign o_busy     = busy_q;
  assign o_finished = fin_q;
  assign o_error    = err_q;
  assign o_cmd_idx  = idx_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: bus decoder + ACK/NACK slave, checked against a transaction-level model.
module tb_i2c_cmd_sequencer;

  localparam int N_CMD     = 10;
  localparam int BYTES     = 3;
  localparam int CLK_DIV   = 4;
  localparam int MAX_RETRY = 3;
  localparam int DW        = BYTES * 8;
  localparam int IW        = $clog2(N_CMD);
`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [DW-1:0] tbl [16];
  logic [IW-1:0] idx;
  logic busy, fin, err, sclk, oen;
  wire  sdat;
  wire  [DW-1:0] cmd_data = tbl[idx];

  logic start2 = 1'b0;
  logic [0:0] idx2;
  logic busy2, fin2, err2, sclk2, oen2;
  wire  sdat2;

  int n_chk = 0;
  int n_err = 0;

  // slave / decoder state
  int  nack_cnt [16];
  int  att_seen [16];
  int  nack_pos;
  bit  nack_now;
  logic slave_bit;
  logic p_scl, p_sda;
  logic [DW-1:0] cur_frame;
  logic [7:0] cur_byte;
  int  cur_nb, bitc, oen_lo, n_start, n_stop;
  logic [DW-1:0] got_data [$];
  int  got_nb [$];

  // model results
  logic [DW-1:0] exp_data [$];
  int  exp_nb [$];
  int  exp_cyc, exp_err, exp_idx;

  assign slave_bit = nack_now && (cur_nb == nack_pos + 1);
  assign sdat  = oen  ? 1'bz : slave_bit;
  assign sdat2 = oen2 ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.N_CMD(N_CMD), .BYTES_PER_CMD(BYTES), .CLK_DIV(CLK_DIV), .MAX_RETRY(MAX_RETRY)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cmd_data(cmd_data),
    .o_cmd_idx(idx), .o_busy(busy), .o_finished(fin), .o_error(err),
    .o_sclk(sclk), .io_sdat(sdat), .o_oen(oen)
  );

  i2c_cmd_sequencer #(.N_CMD(1), .BYTES_PER_CMD(2), .CLK_DIV(2), .MAX_RETRY(MAX_RETRY)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_cmd_data(16'hA55A),
    .o_cmd_idx(idx2), .o_busy(busy2), .o_finished(fin2), .o_error(err2),
    .o_sclk(sclk2), .io_sdat(sdat2), .o_oen(oen2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dec_reset();
    p_scl = 1'b1; p_sda = 1'b1;
    cur_frame = '0; cur_byte = '0; cur_nb = 0; bitc = 0; oen_lo = 0; nack_now = 1'b0;
  endtask

  // Decode START/STOP/bits from the sampled bus and check every ACK window length.
  task automatic decode();
    logic s;
    s = sdat;
    if (!rst_n) begin dec_reset(); return; end
    if (p_scl && sclk && p_sda && !s) begin
      n_start++;
      cur_frame = '0; cur_byte = '0; cur_nb = 0; bitc = 0;
      nack_now = (att_seen[idx] < nack_cnt[idx]);
      att_seen[idx]++;
    end else if (p_scl && sclk && !p_sda && s) begin
      n_stop++;
      got_data.push_back(cur_frame);
      got_nb.push_back(cur_nb);
    end else if (!p_scl && sclk && oen) begin
      cur_byte = {cur_byte[6:0], s};
      bitc++;
      if (bitc == 8) begin
        cur_frame = {cur_frame[DW-9:0], cur_byte};
        cur_nb++;
        bitc = 0;
      end
    end
    if (!oen) oen_lo++;
    else if (oen_lo != 0) begin
      chk("ack_window_len", 64'(oen_lo), 64'(2 * CLK_DIV));
      oen_lo = 0;
    end
    p_scl = sclk;
    p_sda = s;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    decode();
  endtask

  // Transaction-level expectation: which frames appear, how long they take, how the run ends.
  task automatic model();
    int tries, nb;
    bit nack, stop;
    exp_data.delete(); exp_nb.delete();
    exp_cyc = 0; exp_err = 0; exp_idx = N_CMD - 1; stop = 1'b0;
    for (int i = 0; i < N_CMD && !stop; i++) begin
      tries = 0;
      while (1) begin
        nack = (tries < nack_cnt[i]);
        nb   = nack ? nack_pos + 1 : BYTES;
        exp_data.push_back(tbl[i] >> (8 * (BYTES - nb)));
        exp_nb.push_back(nb);
        exp_cyc += (1 + 18 * nb + 3) * CLK_DIV;
        if (!nack) break;
        if (RETRY && tries < MAX_RETRY) tries++;
        else begin exp_err = 1; exp_idx = i; stop = 1'b1; break; end
      end
    end
  endtask

  task automatic run_seq(input string tag, input int poke_at);
    int n, fin_at, busy_bad, extra_fin, lim;
    model();
    got_data.delete(); got_nb.delete();
    n_start = 0; n_stop = 0;
    for (int i = 0; i < 16; i++) att_seen[i] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    chk({tag, " busy_at_start"}, 64'(busy), 64'(1));
    chk({tag, " err_cleared"},   64'(err),  64'(0));
    chk({tag, " start_sda"},     64'(sdat), 64'(0));
    fin_at = -1; busy_bad = 0; lim = exp_cyc + 100;
    while (fin_at < 0 && n <= lim) begin
      if (fin) fin_at = n;
      else begin
        if (!busy) busy_bad++;
        start = (n == poke_at);
        tick();
        n++;
      end
    end
    start = 1'b0;
    chk({tag, " finish_cycle"}, 64'(fin_at), 64'(1 + exp_cyc));
    chk({tag, " busy_gaps"},    64'(busy_bad), 64'(0));
    chk({tag, " busy_in_done"}, 64'(busy), 64'(0));
    extra_fin = 0;
    repeat (3) begin
      tick();
      if (fin || busy) extra_fin++;
    end
    chk({tag, " single_pulse"}, 64'(extra_fin), 64'(0));
    chk({tag, " error"},        64'(err), 64'(exp_err));
    chk({tag, " idx"},          64'(idx), 64'(exp_idx));
    chk({tag, " n_frames"},     64'(got_nb.size()), 64'(exp_nb.size()));
    chk({tag, " n_start"},      64'(n_start), 64'(exp_nb.size()));
    chk({tag, " n_stop"},       64'(n_stop),  64'(exp_nb.size()));
    for (int i = 0; i < exp_nb.size() && i < got_nb.size(); i++) begin
      chk($sformatf("%s frame%0d_len", tag, i),  64'(got_nb[i]),   64'(exp_nb[i]));
      chk($sformatf("%s frame%0d_data", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
    end
  endtask

  task automatic new_table();
    for (int i = 0; i < 16; i++) begin
      tbl[i] = DW'($urandom);
      nack_cnt[i] = 0;
    end
    nack_pos = $urandom_range(0, BYTES - 1);
  endtask

  initial begin
    int n, f2;
    new_table();
    tbl[0] = 24'h34_1E_00;
    dec_reset();
    n_start = 0; n_stop = 0;
    repeat (3) @(negedge clk);
    chk("rst sclk", 64'(sclk), 64'(1));
    chk("rst oen",  64'(oen),  64'(1));
    chk("rst sda",  64'(sdat), 64'(1));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst fin",  64'(fin),  64'(0));
    chk("rst err",  64'(err),  64'(0));
    chk("rst idx",  64'(idx),  64'(0));
    rst_n = 1'b1;
    tick(); tick();

    // Short config: 1 command, 2 bytes, divider 2.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 1; f2 = -1;
    while (f2 < 0 && n < 200) begin
      if (fin2) f2 = n;
      else begin tick(); n++; end
    end
    chk("div2 finish_cycle", 64'(f2),   64'(1 + 80));
    chk("div2 error",        64'(err2), 64'(0));
    tick(); tick();

    // All ACK, with a stray start pulse mid-sequence.
    run_seq("allack", 500);

    new_table();
    nack_cnt[4] = 2;
    run_seq("nack4x2", 0);

    new_table();
    nack_cnt[2] = 1000;
    run_seq("nack2perm", 0);

    // Reset in the middle of a transfer, then a clean rerun.
    new_table();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300 + $urandom_range(0, 40)) tick();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst sclk", 64'(sclk), 64'(1));
    chk("midrst sda",  64'(sdat), 64'(1));
    chk("midrst oen",  64'(oen),  64'(1));
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst idx",  64'(idx),  64'(0));
    @(negedge clk);
    dec_reset();
    tick();
    rst_n = 1'b1;
    tick(); tick();
    nack_cnt[$urandom_range(0, N_CMD - 1)] = $urandom_range(1, 5);
    run_seq("after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Parametrised I2C write-only command sequencer. Steps through a caller-supplied table of N_CMD fixed-length write transactions and emits each as START, address/data bytes, STOP on a single open-drain bus. It adds a programmable SCL divider, ACK checking with bounded retry, and busy/error status. It sits between the top-level power-up controller and the codec's I2C pins, and is the general replacement for fixed codec-init sequencers.

## Interface
- N_CMD, 10: number of commands in the table (≥1).
- BYTES_PER_CMD, 3: bytes per command, slave address byte included (≥1).
- CLK_DIV, 4: i_clk cycles per bus phase (≥2); one SCL bit period = 2·CLK_DIV.
- MAX_RETRY, 3: retries per command after NACK (only with retry compiled in).
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start request; sampled only in IDLE.
- i_cmd_data  in  BYTES_PER_CMD·8  command selected by o_cmd_idx, combinational from caller; MSB byte sent first.
- o_cmd_idx  out  $clog2(N_CMD) (min 1)  index of the current command.
- o_busy  out  1  high from START entry until o_finished.
- o_finished  out  1  one-cycle pulse at sequence end (success or abort).
- o_error  out  1  sticky abort flag; cleared on next accepted i_start.
- o_sclk  out  1  SCL.
- io_sdat  inout  1  SDA; driven when o_oen=1, else 'z.
- o_oen  out  1  SDA output enable.

## Operation
- States: IDLE, START, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP_LO, STOP_HI, STOP_REL, DONE.
- A phase counter counts 0..CLK_DIV-1. Every non-IDLE/DONE state lasts exactly CLK_DIV cycles. Transitions occur on the terminal count.
- IDLE: SCL=1, SDA=1, oen=1. i_start → START, clear o_error, o_cmd_idx=0, retry count=0.
- START: SCL=1, SDA=0. Latch i_cmd_data into shift register. → BIT_LO.
- BIT_LO/BIT_HI: SCL=0/1, SDA=shift[MSB]. On BIT_HI exit, shift left. After bit 7 → ACK_LO, else BIT_LO.
- ACK_LO/ACK_HI: SCL=0/1, oen=0. Sample io_sdat on the last cycle of ACK_HI.
- After ACK_HI:
  - ACK (0) and more bytes → BIT_LO.
  - ACK on last byte → STOP_LO.
  - NACK (1 or z-pulled-high) → STOP_LO with nack flag set.
- STOP_LO: SCL=0, SDA=0. STOP_HI: SCL=1, SDA=0. STOP_REL: SCL=1, SDA=1 (rising SDA = STOP, also the bus-free gap).
- After STOP_REL:
  - No NACK and o_cmd_idx<N_CMD-1 → increment index, retry=0, → START.
  - No NACK on last command → DONE.
  - NACK → retry/abort per Configuration.
- DONE: o_finished=1 for one cycle, o_busy=0. → IDLE.
- i_start while busy is ignored. i_cmd_data changes after latch are ignored.
- o_cmd_idx holds its last value in IDLE; after an abort it holds the failing index.

## Timing
- Reset values: o_sclk=1, o_oen=1, SDA driven 1, o_busy=0, o_finished=0, o_error=0, o_cmd_idx=0. State=IDLE, all counters 0.
- Reset asserted mid-transfer: bus returns to idle levels immediately (async). No STOP is generated.
- i_start high at edge k → START begins cycle k+1 and o_busy=1 from cycle k+1.
- Per command: (1 + 18·BYTES_PER_CMD + 3)·CLK_DIV cycles. Defaults: 58·4 = 232.
- Success: o_finished pulses N_CMD·232 cycles after START entry. Defaults: cycle k+1+2320.
- SDA changes only while SCL=0, except the START and STOP edges.
- All outputs are registered.

## Configuration
- I2C_SEQ_RETRY_EN defined: on NACK with retry<MAX_RETRY, increment retry, re-latch the same command, → START. On NACK with retry=MAX_RETRY, set o_error and → DONE.
- Undefined: any NACK sets o_error and → DONE. The retry counter and MAX_RETRY are unused.

## Structure
- i2c_seq_pkg holds:
  - the state enum;
  - phase/bit widths;
  - a default codec-init command table function for top-level use.
- Sub-module i2c_phase_timer: CLK_DIV counter with enable, clear, and terminal-count pulse.
- Sequencer FSM, shift register, bit/byte/command counters, and retry counter live in i2c_cmd_sequencer.

## Test plan
- Defaults, slave model ACKs all; table returns 24'h34_1E_00 for idx 0: SDA bytes 0x34, 0x1E, 0x00 decoded on SCL rising edges. o_finished at k+1+2320, o_error=0, o_cmd_idx=9.
- CLK_DIV=2, N_CMD=1, BYTES_PER_CMD=2, all ACK: o_finished exactly (1+36+3)·2=80 cycles after START entry.
- Retry enabled, MAX_RETRY=3, slave NACKs idx 4 twice then ACKs: command 4 appears 3 times on bus, each separated by STOP; o_error=0.
- Slave NACKs idx 2 permanently: with macro, 4 attempts then o_error=1, o_cmd_idx=2, one o_finished pulse. Without macro, 1 attempt then the same response.
- i_start pulsed mid-sequence: ignored, timing unchanged. i_rst_n low mid-byte: same cycle o_sclk=1, SDA=1, o_busy=0. A new i_start then runs from idx 0.
- Protocol checker runs throughout: SDA stable while SCL high except START/STOP; o_oen=0 only in ACK_LO/ACK_HI.
